selector_output_fifo: RTL and testbench
=======================================

# selector_output_fifo

Output buffer and serializer directly downstream of `data_selector`.
- Accepts the scheduled `DATA_WIDTH*SELECTOR_OUTPUTS_PER_BUS`-bit words into a small FIFO.
- Drives the upstream `wBusy` back-pressure signal from the FIFO fill level.
- Emits each word as `SELECTOR_OUTPUTS_PER_BUS` consecutive `DATA_WIDTH`-bit beats on a valid/ready output channel, lane 0 first.

## Interface
Parameters:
- `DATA_WIDTH`, 4, width of one output beat.
- `SELECTOR_OUTPUTS_PER_BUS`, 4, beats per word (`LANES`); word width `W = DATA_WIDTH*LANES`.
- `FIFO_DEPTH`, 8, word entries; power of two, ≥2.
- `BUSY_THRESHOLD`, 6, level at or above which `wBusy` is asserted; 1..`FIFO_DEPTH`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `data_in` carries a word this cycle.
- `data_in`  in  W  word from `data_selector.data_out`.
- `wBusy`  out  1  back-pressure to `data_selector`.
- `level`  out  `$clog2(FIFO_DEPTH+1)`  FIFO entries held; the word in the serializer is excluded.
- `out_valid`  out  1  `out_data` holds a valid beat.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  `DATA_WIDTH`  current beat.
- `out_last`  out  1  current beat is lane `LANES-1`.
- `overflow`  out  1  sticky drop flag; present only with `SELECTOR_FIFO_OVF_EN`.

## Operation
- Reset state: FIFO pointers 0, `level=0`, serializer `IDLE`, lane index 0, shift register 0. Outputs `out_valid=0`, `out_data=0`, `out_last=0`, `wBusy=0`, `overflow=0`.
- Push: when `in_valid=1` and (`level<FIFO_DEPTH` or a pop occurs in the same cycle), `data_in` is written at the write pointer. Pointers wrap modulo `FIFO_DEPTH`.
- Drop: when `in_valid=1`, `level==FIFO_DEPTH` and no pop occurs in that cycle:
  - the word is discarded and `level` is unchanged;
  - `overflow` is set, if compiled in.
- Level update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `wBusy = (level >= BUSY_THRESHOLD)`, decoded from the registered `level`.
- Serializer FSM:
  - `IDLE`: `out_valid=0`. If `level>0`, pop the head word into the shift register, set lane index 0 and go to `LOAD`.
  - `LOAD`: `out_valid=1`, `out_data = word[lane*DATA_WIDTH +: DATA_WIDTH]`, `out_last = (lane==LANES-1)`.
  - On `out_valid & out_ready` with lane < `LANES-1`: lane increments.
  - On `out_valid & out_ready` with lane = `LANES-1`:
    - if `level>0`, pop the next word and restart at lane 0 in `LOAD` with no bubble cycle;
    - otherwise go to `IDLE`.
  - `out_ready=0`: hold `out_data`, `out_last` and lane stable. `out_valid` is never withdrawn once raised.
- `out_ready` is ignored in `IDLE`.

## Timing
- Write latency: a word accepted at edge N counts in `level` after edge N.
- First-beat latency: with the serializer idle, `out_valid` rises after edge N+1, one cycle after the write.
- Throughput: one beat per cycle with `out_ready=1`. Sustained input is 1 word per `LANES` cycles; faster input fills the FIFO.
- `wBusy` asserts in the cycle after the push that brings `level` to `BUSY_THRESHOLD`. `data_selector` registers its output, so at least one more word can arrive after `wBusy` asserts. `BUSY_THRESHOLD ≤ FIFO_DEPTH-2` guarantees no drop.
- Reset mid-operation: the word in flight and all FIFO contents are lost. All outputs return to reset values immediately, asynchronously.

## Configuration
- `SELECTOR_FIFO_OVF_EN` defined:
  - `overflow` port and sticky register exist;
  - the flag sets on any dropped word;
  - it clears only on `rst`.
- Not defined:
  - no `overflow` port and no register;
  - drops are silent;
  - all other behaviour is identical.

## Test plan
- Reset: assert `rst` mid-cycle without a clock edge. Expect all outputs 0 immediately, `level=0`, FSM in `IDLE`.
- Single word: push `0xA5C3` with `out_ready=1`. Expect beats `3,C,5,A` on consecutive cycles, `out_last` only on `A`, then `out_valid=0`.
- Back-to-back: push `0x1234` and `0xBEEF` on consecutive cycles, `out_ready=1`. Expect 8 contiguous beats `4,3,2,1,F,E,E,B` with no bubble and `out_last` on beats 4 and 8.
- Fill and busy: hold `out_ready=0` and push words 1..10 one per cycle.
  - `wBusy` rises the cycle after `level` reaches 6.
  - The serializer holds word 1; words 2..9 fill the FIFO (`level=8`).
  - Word 10 is dropped and `overflow=1` with the macro defined.
- Backpressure: toggle `out_ready` 1,0,0,1 during the word `0x9876`. Expect `out_data=6` held through the stall, then `7,8,9` delivered, with no lane skipped or repeated.
- Simultaneous push/pop at full: with `level=8`, push while the last lane is accepted. Expect the word accepted, `level` stays 8, and no `overflow`.

Source files
------------

// File: rtl/selector_output_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : selector_output_fifo_if
// Description : Handshake bundle between data_selector, the output FIFO and
//               the beat consumer. The master side is the environment
//               (word source and beat sink); the slave side is the FIFO.
//               The overflow signal exists only with SELECTOR_FIFO_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface selector_output_fifo_if #(
    parameter int DATA_WIDTH               = 4,
    parameter int SELECTOR_OUTPUTS_PER_BUS = 4,
    parameter int FIFO_DEPTH               = 8
);
    localparam int c_word_w = DATA_WIDTH * SELECTOR_OUTPUTS_PER_BUS;
    localparam int c_lvl_w  = $clog2(FIFO_DEPTH + 1);

    logic                  in_valid;
    logic [c_word_w-1:0]   data_in;
    logic                  wBusy;
    logic [c_lvl_w-1:0]    level;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
`ifdef SELECTOR_FIFO_OVF_EN
    logic                  overflow;
`endif

    modport master (
        output in_valid,
        output data_in,
        output out_ready,
        input  wBusy,
        input  level,
        input  out_valid,
        input  out_data,
        input  out_last
`ifdef SELECTOR_FIFO_OVF_EN
        ,
        input  overflow
`endif
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  out_ready,
        output wBusy,
        output level,
        output out_valid,
        output out_data,
        output out_last
`ifdef SELECTOR_FIFO_OVF_EN
        ,
        output overflow
`endif
    );
endinterface : selector_output_fifo_if
`default_nettype wire

// File: rtl/selector_output_fifo.sv
`default_nettype none
// ============================================================================
// Module      : selector_output_fifo
// Description : Word FIFO behind data_selector plus a serializer that emits
//               each word as SELECTOR_OUTPUTS_PER_BUS beats, lane 0 first,
//               on a valid/ready channel. wBusy back-pressures the selector
//               from the registered fill level.
//               Optional feature macro: SELECTOR_FIFO_OVF_EN adds a sticky
//               overflow flag set whenever a word is dropped at full.
// Revision    : 1.0 - initial release
// ============================================================================
module selector_output_fifo #(
    parameter int DATA_WIDTH               = 4,
    parameter int SELECTOR_OUTPUTS_PER_BUS = 4,
    parameter int FIFO_DEPTH               = 8,
    parameter int BUSY_THRESHOLD           = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    selector_output_fifo_if.slave  bus
);
    localparam int c_lanes  = SELECTOR_OUTPUTS_PER_BUS;
    localparam int c_word_w = DATA_WIDTH * c_lanes;
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w  = $clog2(FIFO_DEPTH + 1);
    localparam int c_lane_w = (c_lanes > 1) ? $clog2(c_lanes) : 1;

    localparam logic [c_lvl_w-1:0]  c_depth     = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_lvl_w-1:0]  c_busy_th   = c_lvl_w'(BUSY_THRESHOLD);
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_lanes - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    // Storage and pointers
    logic [c_word_w-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_lvl_w-1:0]    r_level;

    // Serializer state and registered outputs
    state_t                r_state;
    logic [c_word_w-1:0]   r_shift;
    logic [c_lane_w-1:0]   r_lane;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;

    logic [c_word_w-1:0]   w_head;
    logic                  w_beat_fire;
    logic                  w_last_fire;
    logic                  w_not_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic [c_lane_w-1:0]   w_next_lane;
    logic [DATA_WIDTH-1:0] w_next_beat;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_beat_fire = r_out_valid & bus.out_ready;
    assign w_last_fire = w_beat_fire & (r_lane == c_last_lane);
    assign w_not_empty = (r_level != '0);
    assign w_full      = (r_level == c_depth);

    // The serializer takes a new word when idle, or seamlessly when its
    // final beat is accepted, so a full FIFO can absorb a word that cycle.
    assign w_pop       = w_not_empty & ((r_state == ST_IDLE) | w_last_fire);
    assign w_push      = bus.in_valid & (~w_full | w_pop);

    assign w_next_lane = r_lane + 1'b1;
    assign w_next_beat = r_shift[int'(w_next_lane) * DATA_WIDTH +: DATA_WIDTH];

    // Word storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
        end
    end

    // Fill level excludes the word currently held by the serializer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Serializer: load a word, step lanes on each accepted beat, chain words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_lane      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state     <= ST_LOAD;
                        r_shift     <= w_head;
                        r_lane      <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_head[DATA_WIDTH-1:0];
                        r_out_last  <= (c_lanes == 1);
                    end
                end
                ST_LOAD: begin
                    if (w_beat_fire) begin
                        if (r_lane != c_last_lane) begin
                            r_lane     <= w_next_lane;
                            r_out_data <= w_next_beat;
                            r_out_last <= (w_next_lane == c_last_lane);
                        end else if (w_pop) begin
                            r_shift    <= w_head;
                            r_lane     <= '0;
                            r_out_data <= w_head[DATA_WIDTH-1:0];
                            r_out_last <= (c_lanes == 1);
                        end else begin
                            r_state     <= ST_IDLE;
                            r_lane      <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wBusy     = (r_level >= c_busy_th);
    assign bus.level     = r_level;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

`ifdef SELECTOR_FIFO_OVF_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = bus.in_valid & w_full & ~w_pop;

    // Sticky drop indicator, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.overflow = r_overflow;
`endif

endmodule : selector_output_fifo
`default_nettype wire

// File: tb/tb_selector_output_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_selector_output_fifo
// Description : Self-checking bench for selector_output_fifo: directed
//               scenarios plus randomized traffic against a queue-based
//               reference model of the FIFO and beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_selector_output_fifo;
    localparam int DW    = 4;
    localparam int L     = 4;
    localparam int DEPTH = 8;
    localparam int TH    = 6;
    localparam int W     = DW * L;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    selector_output_fifo_if #(
        .DATA_WIDTH(DW), .SELECTOR_OUTPUTS_PER_BUS(L), .FIFO_DEPTH(DEPTH)
    ) bus ();

    selector_output_fifo #(
        .DATA_WIDTH(DW), .SELECTOR_OUTPUTS_PER_BUS(L),
        .FIFO_DEPTH(DEPTH), .BUSY_THRESHOLD(TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: words waiting, plus the word being sent beat by beat
    logic [W-1:0] m_q[$];
    bit           m_act;
    logic [W-1:0] m_word;
    int           m_lane;
    bit           m_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Captured beats of the current directed scenario
    logic [DW-1:0] cap_d[$];
    bit            cap_l[$];
    int            cap_t[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_act  = 0;
        m_word = '0;
        m_lane = 0;
        m_ovf  = 0;
    endtask

    task automatic check_all();
        chk("level", 32'(bus.level), 32'(m_q.size()));
        chk("wBusy", 32'(bus.wBusy), 32'(m_q.size() >= TH));
        chk("out_valid", 32'(bus.out_valid), 32'(m_act));
        if (m_act) begin
            chk("out_data", 32'(bus.out_data), 32'((m_word >> (m_lane * DW)) & ((1 << DW) - 1)));
            chk("out_last", 32'(bus.out_last), 32'(m_lane == L - 1));
        end
`ifdef SELECTOR_FIFO_OVF_EN
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, check after it
    task automatic step(input bit iv, input logic [W-1:0] din, input bit rdy);
        int  sz;
        bit  fire, pop, full;
        bus.in_valid  = iv;
        bus.data_in   = din;
        bus.out_ready = rdy;
        @(posedge clk);
        cyc++;
        sz   = m_q.size();
        fire = m_act && rdy;
        pop  = (sz > 0) && (!m_act || (fire && m_lane == L - 1));
        full = (sz == DEPTH);
        if (fire) begin
            if (m_lane == L - 1) m_act = 0;
            else                 m_lane++;
        end
        if (pop) begin
            m_word = m_q.pop_front();
            m_lane = 0;
            m_act  = 1;
        end
        if (iv) begin
            if (!full || pop) m_q.push_back(din);
            else              m_ovf = 1;
        end
        #1;
        check_all();
        if (bus.out_valid === 1'b1) begin
            cap_d.push_back(bus.out_data);
            cap_l.push_back(bus.out_last);
            cap_t.push_back(cyc);
        end
    endtask

    task automatic cap_clear();
        cap_d.delete();
        cap_l.delete();
        cap_t.delete();
    endtask

    // Compare captured beats with an expected list; flag any bubble
    task automatic cap_expect(input string tag, input logic [DW-1:0] exp_d[$], input bit exp_l[$]);
        chk({tag, "_count"}, 32'(cap_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            chk({tag, "_data"}, 32'(cap_d[i]), 32'(exp_d[i]));
            chk({tag, "_last"}, 32'(cap_l[i]), 32'(exp_l[i]));
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 0;
        bus.data_in   = '0;
        bus.out_ready = 0;
        rst = 1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_all();
    endtask

    // Empty the DUT with a random consumer; a blown budget is a failure
    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(0, '0, $urandom_range(0, 3) != 0);
            done = !m_act && (m_q.size() == 0);
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] ed[$];
        bit            el[$];
        bit            busy_seen[$];

        // Reset applied at time zero, checked before any clock edge
        rst           = 1;
        bus.in_valid  = 0;
        bus.data_in   = '0;
        bus.out_ready = 0;
        model_clear();
        #1;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_busy", 32'(bus.wBusy), 32'd0);
        do_reset();

        // Single word: beats 3,C,5,A with last only on A
        cap_clear();
        step(1, 16'hA5C3, 1);
        chk("single_level_after_write", 32'(bus.level), 32'd1);
        chk("single_no_valid_yet", 32'(bus.out_valid), 32'd0);
        repeat (6) step(0, '0, 1);
        ed = '{4'h3, 4'hC, 4'h5, 4'hA};
        el = '{0, 0, 0, 1};
        cap_expect("single", ed, el);
        chk("single_idle_after", 32'(bus.out_valid), 32'd0);

        // Back-to-back words with no bubble between them
        cap_clear();
        step(1, 16'h1234, 1);
        step(1, 16'hBEEF, 1);
        repeat (10) step(0, '0, 1);
        ed = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF, 4'hE, 4'hE, 4'hB};
        el = '{0, 0, 0, 1, 0, 0, 0, 1};
        cap_expect("b2b", ed, el);
        if (cap_t.size() == 8) begin
            chk("b2b_contiguous", 32'(cap_t[7] - cap_t[0]), 32'd7);
        end

        // Backpressure: beat 6 held through a two-cycle stall
        cap_clear();
        step(1, 16'h9876, 1);
        step(0, '0, 1);
        step(0, '0, 0);
        step(0, '0, 0);
        repeat (5) step(0, '0, 1);
        ed = '{4'h6, 4'h6, 4'h6, 4'h7, 4'h8, 4'h9};
        el = '{0, 0, 0, 0, 0, 1};
        cap_expect("bp", ed, el);

        // Fill with the consumer stalled: busy at level 6, word 10 dropped
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1, 16'(k), 0);
            busy_seen.push_back(bus.wBusy);
        end
        for (int k = 1; k <= 10; k++) begin
            chk("fill_busy", 32'(busy_seen[k-1]), 32'(k >= 7));
        end
        chk("fill_level", 32'(bus.level), 32'd8);
`ifdef SELECTOR_FIFO_OVF_EN
        chk("fill_overflow", 32'(bus.overflow), 32'd1);
`endif
        drain();

        // Push exactly as the last lane is taken while full
        do_reset();
        for (int k = 1; k <= 9; k++) step(1, 16'(k + 16'h40), 0);
        chk("full_level", 32'(bus.level), 32'd8);
        repeat (3) step(0, '0, 1);
        step(1, 16'hFACE, 1);
        chk("simul_level", 32'(bus.level), 32'd8);
`ifdef SELECTOR_FIFO_OVF_EN
        chk("simul_no_overflow", 32'(bus.overflow), 32'd0);
`endif
        drain();

        // Random traffic: light load, then heavy load that provokes drops
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 5) == 0, 16'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1);

        // Asynchronous reset in the middle of a cycle, no edge involved
        #2;
        rst = 1;
        #1;
        chk("async_rst_level", 32'(bus.level), 32'd0);
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_data", 32'(bus.out_data), 32'd0);
        chk("async_rst_last", 32'(bus.out_last), 32'd0);
        chk("async_rst_busy", 32'(bus.wBusy), 32'd0);
`ifdef SELECTOR_FIFO_OVF_EN
        chk("async_rst_ovf", 32'(bus.overflow), 32'd0);
`endif
        do_reset();

        // Recovery after reset
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 2) != 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_selector_output_fifo
`default_nettype wire
